// File: rtl/stopwatch_bcd_core.sv
// Four-digit BCD stopwatch (SS.hh) with debounced start/clear buttons,
// run/pause/idle control, lap hold and saturating overflow at 99.99.
module stopwatch_bcd_core #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [15:0] value,
  output logic        running,
  output logic        overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;

  // Button index 0 is start, index 1 is clear.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d, deb_prev_q, deb_prev_d, press_q, press_d;
  logic [DW-1:0] dbc_q [2];
  logic [DW-1:0] dbc_d [2];

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   count_q, count_d, lap_q, lap_d;
  logic          lap_act_q, lap_act_d, ovf_q, ovf_d;
  logic          start_p, clear_p, tick, sat;

  assign raw = {btn_clear, btn_start};

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    // Pulse one cycle after the debounced level rises; releases are ignored.
    press_d    = deb_q & ~deb_prev_q;
    for (int i = 0; i < 2; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dbc_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  assign start_p = press_q[0];
  assign clear_p = press_q[1];
  assign tick    = (state_q == S_RUN) && (pre_q == PW'(TICK_DIV - 1));
  assign sat     = tick && (count_q == 16'h9999);

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    count_d   = count_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    ovf_d     = ovf_q;

    if (state_q == S_RUN) pre_d = tick ? '0 : pre_q + 1'b1;

    // The tick lands first; a coincident button transition is applied on top.
    if (tick) begin
      if (sat) begin
        ovf_d   = 1'b1;
        state_d = S_PAUSED;
      end else begin
        count_d = bcd_inc(count_q);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        if (start_p) begin
          state_d   = S_PAUSED;
          lap_act_d = 1'b0;
        end else if (clear_p) begin
          if (!lap_act_q) begin
            lap_d     = count_q;
            lap_act_d = 1'b1;
          end else begin
            lap_act_d = 1'b0;
          end
        end
      end
      S_PAUSED: begin
        if (start_p) begin
          state_d = S_RUN;
        end else if (clear_p) begin
          state_d   = S_IDLE;
          count_d   = '0;
          ovf_d     = 1'b0;
          lap_act_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      dbc_q      <= '{default: '0};
      state_q    <= S_IDLE;
      pre_q      <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      lap_act_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      dbc_q      <= dbc_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      lap_act_q  <= lap_act_d;
      ovf_q      <= ovf_d;
    end
  end

  assign value    = lap_act_q ? lap_q : count_q;
  assign running  = (state_q == S_RUN);
  assign overflow = ovf_q;

endmodule
